// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes and
// the select/control codes driven onto the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   function automatic logic [1:0] immSrcFor(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALUOp and the instruction
// function fields.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] i_aluOp,
   input  logic [2:0] i_funct3,
   input  logic       i_opb5,
   input  logic       i_funct7b5,
   output logic [2:0] o_aluControl
);

   always_comb begin
      o_aluControl = ALU_ADD;
      case (i_aluOp)
         ALUOP_ADD: o_aluControl = ALU_ADD;
         ALUOP_SUB: o_aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            // Only R-type sub sets op[5]; addi with imm[10]=1 must stay an add.
            case (i_funct3)
               3'b000:  o_aluControl = (i_opb5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_aluControl = ALU_SLT;
               3'b110:  o_aluControl = ALU_OR;
               3'b111:  o_aluControl = ALU_AND;
               default: o_aluControl = ALU_ADD;
            endcase
         end
         default: o_aluControl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath. Define MCCTRL_BNE_EN to
// let the BEQ state also execute bne (funct3=001 branches on ~Zero).
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl
);

   state_t     r_state;
   state_t     w_nextState;
   logic       w_pcUpdate;
   logic       w_branch;
   logic       w_branchCond;
   logic       w_irWrite;
   logic       w_regWrite;
   logic       w_memWrite;
   logic [1:0] w_aluOp;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_pcUpdate  = 1'b0;
      w_branch    = 1'b0;
      w_irWrite   = 1'b0;
      w_regWrite  = 1'b0;
      w_memWrite  = 1'b0;
      w_aluOp     = ALUOP_ADD;
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RS2;
      case (r_state)
         FETCH: begin
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            w_irWrite  = MemReady;
            w_pcUpdate = MemReady;
            if (MemReady) w_nextState = DECODE;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: w_nextState = MEMADR;
               OP_RTYPE:          w_nextState = EXECUTER;
               OP_ITYPE:          w_nextState = EXECUTEI;
               OP_JAL:            w_nextState = JAL;
               OP_BRANCH:         w_nextState = BEQ;
               default:           w_nextState = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcA     = SRCA_RS1;
            ALUSrcB     = SRCB_IMM;
            w_nextState = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) w_nextState = MEMWB;
         end
         MEMWB: begin
            ResultSrc   = RES_DATA;
            w_regWrite  = 1'b1;
            w_nextState = FETCH;
         end
         MEMWRITE: begin
            AdrSrc     = 1'b1;
            w_memWrite = 1'b1;
            if (MemReady) w_nextState = FETCH;
         end
         EXECUTER: begin
            ALUSrcA     = SRCA_RS1;
            ALUSrcB     = SRCB_RS2;
            w_aluOp     = ALUOP_FUNCT;
            w_nextState = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA     = SRCA_RS1;
            ALUSrcB     = SRCB_IMM;
            w_aluOp     = ALUOP_FUNCT;
            w_nextState = ALUWB;
         end
         ALUWB: begin
            ResultSrc   = RES_ALUOUT;
            w_regWrite  = 1'b1;
            w_nextState = FETCH;
         end
         JAL: begin
            ALUSrcA     = SRCA_OLDPC;
            ALUSrcB     = SRCB_FOUR;
            w_pcUpdate  = 1'b1;
            w_nextState = ALUWB;
         end
         BEQ: begin
            ALUSrcA     = SRCA_RS1;
            ALUSrcB     = SRCB_RS2;
            w_aluOp     = ALUOP_SUB;
            w_branch    = 1'b1;
            w_nextState = FETCH;
         end
         default: w_nextState = FETCH;
      endcase
   end

`ifdef MCCTRL_BNE_EN
   assign w_branchCond = (funct3 == 3'b001) ? ~Zero : Zero;
`else
   assign w_branchCond = Zero;
`endif

   // Enables are gated by reset itself so an async reset mid-write aborts it at once.
   assign PCWrite  = ~reset & (w_pcUpdate | (w_branch & w_branchCond));
   assign IRWrite  = ~reset & w_irWrite;
   assign RegWrite = ~reset & w_regWrite;
   assign MemWrite = ~reset & w_memWrite;
   assign ImmSrc   = immSrcFor(op);

   alu_decoder u_aluDecoder (
      .i_aluOp      (w_aluOp),
      .i_funct3     (funct3),
      .i_opb5       (op[5]),
      .i_funct7b5   (funct7b5),
      .o_aluControl (ALUControl)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; each task walks one
// instruction class cycle by cycle against hand-derived expectations.
module tb_multicycle_controller;
   import riscv_ctrl_pkg::*;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;

   int errors = 0;
   int checks = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000 || dut.r_state !== FETCH) begin
            errors++;
            $display("[TB] FAIL reset_hold: enables=%b state=%0d, required 0000 state=%0d",
                     {PCWrite, IRWrite, RegWrite, MemWrite}, dut.r_state, FETCH);
         end
      end
      reset = 1'b0;
      #1;
      checks++;
      if (IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release: IRWrite=%b PCWrite=%b, required 1 1", IRWrite, PCWrite);
      end
      MemReady = 1'b0;
      #1;
      checks++;
      if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_stall_en: IRWrite=%b PCWrite=%b, required 0 0", IRWrite, PCWrite);
      end
      step();
      checks++;
      if (dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL fetch_stall_hold: state=%0d, required %0d", dut.r_state, FETCH);
      end
   endtask

   task automatic test_rtype(input logic f7, input logic [2:0] expCtrl);
      op = OP_RTYPE; funct3 = 3'b000; funct7b5 = f7; MemReady = 1'b1; Zero = 1'b0;
      #1;
      step();
      checks++;
      if (dut.r_state !== DECODE || RegWrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rtype_decode: state=%0d RegWrite=%b, required %0d 0", dut.r_state, RegWrite, DECODE);
      end
      step();
      checks++;
      if (dut.r_state !== EXECUTER || ALUControl !== expCtrl || RegWrite !== 1'b0 ||
          ALUSrcA !== SRCA_RS1 || ALUSrcB !== SRCB_RS2) begin
         errors++;
         $display("[TB] FAIL rtype_exec: state=%0d ctrl=%b RegWrite=%b A=%b B=%b, required %0d %b 0 10 00",
                  dut.r_state, ALUControl, RegWrite, ALUSrcA, ALUSrcB, EXECUTER, expCtrl);
      end
      step();
      checks++;
      if (dut.r_state !== ALUWB || RegWrite !== 1'b1 || ResultSrc !== RES_ALUOUT) begin
         errors++;
         $display("[TB] FAIL rtype_wb: state=%0d RegWrite=%b ResultSrc=%b, required %0d 1 00",
                  dut.r_state, RegWrite, ResultSrc, ALUWB);
      end
      step();
      checks++;
      if (dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL rtype_done: state=%0d, required %0d", dut.r_state, FETCH);
      end
   endtask

   task automatic test_itype(input logic [2:0] f3, input logic f7, input logic [2:0] expCtrl);
      op = OP_ITYPE; funct3 = f3; funct7b5 = f7; MemReady = 1'b1;
      #1;
      step();
      step();
      checks++;
      if (dut.r_state !== EXECUTEI || ALUControl !== expCtrl || ALUSrcB !== SRCB_IMM || ImmSrc !== IMM_I) begin
         errors++;
         $display("[TB] FAIL itype_exec: state=%0d ctrl=%b B=%b imm=%b, required %0d %b 01 00",
                  dut.r_state, ALUControl, ALUSrcB, ImmSrc, EXECUTEI, expCtrl);
      end
      step();
      step();
      checks++;
      if (dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL itype_done: state=%0d, required %0d", dut.r_state, FETCH);
      end
   endtask

   task automatic test_lw_stall();
      op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0; MemReady = 1'b1;
      #1;
      step();
      step();
      checks++;
      if (dut.r_state !== MEMADR || ALUSrcA !== SRCA_RS1 || ALUSrcB !== SRCB_IMM) begin
         errors++;
         $display("[TB] FAIL lw_memadr: state=%0d A=%b B=%b, required %0d 10 01", dut.r_state, ALUSrcA, ALUSrcB, MEMADR);
      end
      MemReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) MemReady = 1'b1;
         #1;
         checks++;
         if (dut.r_state !== MEMREAD || AdrSrc !== 1'b1 || RegWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lw_memread%0d: state=%0d AdrSrc=%b RegWrite=%b, required %0d 1 0",
                     i, dut.r_state, AdrSrc, RegWrite, MEMREAD);
         end
      end
      step();
      checks++;
      if (dut.r_state !== MEMWB || RegWrite !== 1'b1 || ResultSrc !== RES_DATA) begin
         errors++;
         $display("[TB] FAIL lw_memwb: state=%0d RegWrite=%b ResultSrc=%b, required %0d 1 01",
                  dut.r_state, RegWrite, ResultSrc, MEMWB);
      end
      step();
      checks++;
      if (dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL lw_cycles: state after 7 cycles=%0d, required %0d", dut.r_state, FETCH);
      end
   endtask

   task automatic test_sw();
      int memWrites = 0;
      int regWrites = 0;
      op = OP_STORE; funct3 = 3'b010; MemReady = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (MemWrite === 1'b1) begin
            memWrites++;
            checks++;
            if (AdrSrc !== 1'b1 || ImmSrc !== IMM_S || dut.r_state !== MEMWRITE) begin
               errors++;
               $display("[TB] FAIL sw_write_sel: AdrSrc=%b ImmSrc=%b state=%0d, required 1 01 %0d",
                        AdrSrc, ImmSrc, dut.r_state, MEMWRITE);
            end
         end
         if (RegWrite === 1'b1) regWrites++;
         step();
      end
      checks++;
      if (memWrites != 1 || regWrites != 0 || dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL sw_counts: memWrites=%0d regWrites=%0d state=%0d, required 1 0 %0d",
                  memWrites, regWrites, dut.r_state, FETCH);
      end
   endtask

   task automatic test_jal();
      op = OP_JAL; MemReady = 1'b1;
      #1;
      step();
      checks++;
      if (ImmSrc !== IMM_J) begin
         errors++;
         $display("[TB] FAIL jal_imm: ImmSrc=%b, required 11", ImmSrc);
      end
      step();
      checks++;
      if (dut.r_state !== JAL || PCWrite !== 1'b1 || RegWrite !== 1'b0 || ALUSrcA !== SRCA_OLDPC) begin
         errors++;
         $display("[TB] FAIL jal_state: state=%0d PCWrite=%b RegWrite=%b A=%b, required %0d 1 0 01",
                  dut.r_state, PCWrite, RegWrite, ALUSrcA, JAL);
      end
      step();
      checks++;
      if (dut.r_state !== ALUWB || RegWrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL jal_wb: state=%0d RegWrite=%b, required %0d 1", dut.r_state, RegWrite, ALUWB);
      end
      step();
   endtask

   task automatic test_branch(input logic [2:0] f3, input logic z);
      logic expPc;
`ifdef MCCTRL_BNE_EN
      expPc = (f3 == 3'b001) ? ~z : z;
`else
      expPc = z;
`endif
      op = OP_BRANCH; funct3 = f3; Zero = 1'b1; MemReady = 1'b1;
      #1;
      step();
      checks++;
      if (dut.r_state !== DECODE || PCWrite !== 1'b0 || ImmSrc !== IMM_B) begin
         errors++;
         $display("[TB] FAIL br_decode: state=%0d PCWrite=%b ImmSrc=%b, required %0d 0 10",
                  dut.r_state, PCWrite, ImmSrc, DECODE);
      end
      Zero = z;
      step();
      checks++;
      if (dut.r_state !== BEQ || PCWrite !== expPc || ALUControl !== ALU_SUB || RegWrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL br_f3_%0d_z%0d: state=%0d PCWrite=%b ctrl=%b RegWrite=%b, required %0d %b 001 0",
                  f3, z, dut.r_state, PCWrite, ALUControl, RegWrite, BEQ, expPc);
      end
      step();
      checks++;
      if (dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL br_done: state=%0d, required %0d", dut.r_state, FETCH);
      end
      Zero = 1'b0;
   endtask

   task automatic test_illegal();
      op = 7'b0000000; funct3 = 3'b000; MemReady = 1'b1; Zero = 1'b1;
      #1;
      step();
      checks++;
      if (dut.r_state !== DECODE || {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL illegal_decode: state=%0d enables=%b, required %0d 0000",
                  dut.r_state, {PCWrite, IRWrite, RegWrite, MemWrite}, DECODE);
      end
      step();
      checks++;
      if (dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL illegal_done: state=%0d, required %0d", dut.r_state, FETCH);
      end
      Zero = 1'b0;
   endtask

   task automatic test_reset_in_memwrite();
      op = OP_STORE; MemReady = 1'b1;
      #1;
      step();
      step();
      MemReady = 1'b0;
      step();
      step();
      checks++;
      if (dut.r_state !== MEMWRITE || MemWrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sw_stall: state=%0d MemWrite=%b, required %0d 1", dut.r_state, MemWrite, MEMWRITE);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (MemWrite !== 1'b0 || dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL reset_mid_write: MemWrite=%b state=%0d, required 0 %0d", MemWrite, dut.r_state, FETCH);
      end
      step();
      reset = 1'b0;
      MemReady = 1'b1;
      #1;
      checks++;
      if (IRWrite !== 1'b1 || dut.r_state !== FETCH) begin
         errors++;
         $display("[TB] FAIL reset_mid_refetch: IRWrite=%b state=%0d, required 1 %0d", IRWrite, dut.r_state, FETCH);
      end
   endtask

   initial begin
      test_reset();
      test_rtype(1'b0, ALU_ADD);
      test_rtype(1'b1, ALU_SUB);
      test_itype(3'b000, 1'b1, ALU_ADD);
      test_itype(3'b110, 1'b0, ALU_OR);
      test_itype(3'b010, 1'b0, ALU_SLT);
      test_lw_stall();
      test_sw();
      test_jal();
      test_branch(3'b000, 1'b1);
      test_branch(3'b000, 1'b0);
      test_branch(3'b001, 1'b1);
      test_branch(3'b001, 1'b0);
      test_illegal();
      test_reset_in_memwrite();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core that replaces the single-cycle datapath in `TOP_V0`. It is a Moore FSM plus combinational ALU and immediate decoders. Every cycle it sequences the shared datapath (PC, IR, ALU, register file, unified instruction/data memory) through fetch, decode, execute, memory and writeback. It sits beside the datapath inside the top level and owns every enable and mux select.

## Interface
Parameters: none.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset; one clock domain
- `op`  in  7  instruction opcode, `Instr[6:0]`
- `funct3`  in  3  `Instr[14:12]`
- `funct7b5`  in  1  `Instr[30]`
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  IR/OldPC enable
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4
- `ImmSrc`  out  2  00 = I-type, 01 = S-type, 10 = B-type, 11 = J-type
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt

## Operation
- State register: async reset to FETCH. All outputs decode from state, `op`, `funct3`, `funct7b5`, `Zero` and `MemReady`. Outputs not listed for a state are 0.
- While `reset` is high: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Selects show FETCH values.
- Internal signals: PCUpdate, Branch, ALUOp[1:0]. PCWrite = PCUpdate | (Branch & Zero).

States:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by `op`:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other opcode -> FETCH; the instruction is a NOP with no enables
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady=1, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1. MemWrite stays asserted while MemReady=0. -> FETCH when MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.

ALU decoder:
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10, by funct3:
  - 000 -> sub if (op[5] & funct7b5), else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - other -> add
- ALUOp 11 -> add.

ImmSrc is decoded from `op` in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.

## Timing
- Cycles per instruction with MemReady held at 1: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal opcode 2.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- A reset asserted mid-instruction returns to FETCH immediately, with no partial write. The first fetch happens on the first rising edge after reset deasserts.

## Configuration
- `MCCTRL_BNE_EN`
  - Defined: the BEQ state also executes bne. With funct3=001, PCWrite = Branch & ~Zero; with funct3=000, PCWrite = Branch & Zero.
  - Undefined: funct3 is ignored in BEQ and PCWrite = Branch & Zero.

## Structure
- `riscv_ctrl_pkg` holds:
  - the `state_t` enum (11 states)
  - opcode localparams
  - ALUOp, ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings
- Sub-module `alu_decoder` (combinational; inputs ALUOp, funct3, op[5], funct7b5) is instantiated once.
- The FSM and output decode stay in the top module.

## Test plan
- Reset held for 3 cycles, then released -> PCWrite/IRWrite/RegWrite/MemWrite stay 0 during reset; state is FETCH; IRWrite=1 and PCWrite=1 on the first cycle after release.
- `add` (op=0110011, funct3=000, funct7b5=0) -> state sequence FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB. With funct7b5=1 -> ALUControl=001.
- `lw` with MemReady=0 for 2 cycles in MEMREAD -> instruction takes 7 cycles; RegWrite=1 only in MEMWB; ResultSrc=01.
- `sw` (op=0100011) -> MemWrite=1 for exactly one cycle with AdrSrc=1 and ImmSrc=01; RegWrite is never asserted.
- `beq` with Zero=1 -> PCWrite=1 in BEQ; with Zero=0 -> PCWrite=0. With `MCCTRL_BNE_EN` defined and funct3=001, both results invert.
- Illegal op 0000000 -> DECODE returns to FETCH; no enable is asserted in DECODE. Reset asserted in MEMWRITE -> MemWrite drops to 0 in the same cycle.
